rv32m_muldiv_unit: RTL

//  Iterative RV32M multiply/divide execution unit, the sequential partner of the combinational ALU in EX.
//  EX stage issues one M-extension op with a START pulse; the unit returns RESULT with a one-cycle DONE pulse.

---
 rtl/rv32m_muldiv_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro RV32M_FAST_MUL_EN: multiplies use a single registered full-width product instead.
module rv32m_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;
    logic [2:0]        op_q;
    logic              sgn_a_q;
    logic              sgn_b_q;
    logic              div0_q;
    logic              ovf_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   b_q;

    logic              sgn_a_in;
    logic              sgn_b_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;
    logic              ovf_in;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     div_diff;
    logic              no_borrow;
    logic [XLEN-1:0]   div_hi_nxt;

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    // Operand signedness: DIV/REM signed both, MULH s*s, MULHSU s*u, everything else unsigned.
    always_comb begin
        if (SELECT[2]) begin
            sgn_a_in = ~SELECT[0] & DATA1[XLEN-1];
            sgn_b_in = ~SELECT[0] & DATA2[XLEN-1];
        end else begin
            sgn_a_in = (SELECT[1:0] == 2'b01 || SELECT[1:0] == 2'b10) & DATA1[XLEN-1];
            sgn_b_in = (SELECT[1:0] == 2'b01) & DATA2[XLEN-1];
        end
        mag_a_in = sgn_a_in ? -DATA1 : DATA1;
        mag_b_in = sgn_b_in ? -DATA2 : DATA2;
        ovf_in   = ~SELECT[0] & (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) & (&DATA2);
    end

`ifdef RV32M_FAST_MUL_EN
    logic [2*XLEN+1:0] fast_a;
    logic [2*XLEN+1:0] fast_b;
    logic [2*XLEN+1:0] fast_prod;
    logic [XLEN-1:0]   fast_result;

    // Sign-extend to full product width so an unsigned multiply yields the signed product bits.
    always_comb begin
        fast_a      = {{(XLEN+1){sgn_a_in}}, DATA1};
        fast_b      = {{(XLEN+1){sgn_b_in}}, DATA2};
        fast_prod   = fast_a * fast_b;
        fast_result = (SELECT[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // One iteration step: multiply adds multiplicand on lo_q[0] and shifts {hi,lo} right;
    // divide shifts the next dividend bit into the partial remainder and trial-subtracts.
    always_comb begin
        mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        rem_sh     = {hi_q, lo_q[XLEN-1]};
        div_diff   = rem_sh - {1'b0, b_q};
        no_borrow  = (rem_sh >= {1'b0, b_q});
        div_hi_nxt = no_borrow ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    end

    // Sign correction and special cases. Divide-by-zero leaves |DATA1| in hi_q, so the
    // sign-corrected remainder already equals DATA1.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (sgn_a_q ^ sgn_b_q) ? -prod : prod;
        quo_fix  = (sgn_a_q ^ sgn_b_q) ? -lo_q : lo_q;
        rem_fix  = sgn_a_q ? -hi_q : hi_q;
        if (!op_q[2]) begin
            fix_result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            fix_result = div0_q ? {XLEN{1'b1}} : (ovf_q ? {1'b1, {(XLEN-1){1'b0}}} : quo_fix);
        end else begin
            fix_result = ovf_q ? {XLEN{1'b0}} : rem_fix;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            op_q     <= '0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (START) begin
                        op_q    <= SELECT;
                        sgn_a_q <= sgn_a_in;
                        sgn_b_q <= sgn_b_in;
                        div0_q  <= (DATA2 == '0);
                        ovf_q   <= ovf_in;
                        hi_q    <= '0;
                        cnt_q   <= '0;
                        if (SELECT[2]) begin
                            lo_q <= mag_a_in;
                            b_q  <= mag_b_in;
                        end else begin
                            lo_q <= mag_b_in;
                            b_q  <= mag_a_in;
                        end
`ifdef RV32M_FAST_MUL_EN
                        if (!SELECT[2]) begin
                            result_q <= fast_result;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= StCalc;
                        end
`else
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
`endif
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    if (op_q[2]) begin
                        hi_q <= div_hi_nxt;
                        lo_q <= {lo_q[XLEN-2:0], no_borrow};
                    end else begin
                        hi_q <= mul_sum[XLEN:1];
                        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StFix;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFix: begin
                    result_q <= fix_result;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule
